unified_buffer: RTL and testbench
=================================

Name: unified_buffer

Overview:
- On-chip word-addressed scratch memory of NB single-port banks, low-order interleaved by address.
- One global DMA port reaches every word, for host/DRAM fill and drain.
- NB PE-side ports, one hard-wired per bank, give the processing elements parallel same-cycle access.
- Sits between the DMA engine and the PE array/systolic datapath.

Parameters:
- DATA_W, 32, word width in bits.
- ADDR_W, 10, global word-address width; total capacity 2^ADDR_W words.
- NB, 4, number of banks; power of two, >=2.
- BANK_BITS (derived, $clog2(NB)), bank-select width.

Ports:
- clk  in  1  single clock; all storage is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- dma_write_en  in  1  DMA write strobe.
- dma_read_en  in  1  DMA read strobe.
- dma_addr  in  ADDR_W  DMA global word address.
- dma_data_in  in  DATA_W  DMA write data.
- dma_data_out  out  DATA_W  DMA read data (registered).
- pe_read_en  in  NB  per-PE read strobe.
- pe_write_en  in  NB  per-PE write strobe.
- pe_addr  in  NB x ADDR_W  per-PE global word address (packed [NB-1:0][ADDR_W-1:0]).
- pe_data_in  in  NB x DATA_W  per-PE write data.
- pe_data_out  out  NB x DATA_W  per-PE read data (registered).

Behaviour:
- Address map:
  - bank = addr[BANK_BITS-1:0]; row = addr[ADDR_W-1:BANK_BITS].
  - Each bank holds 2^(ADDR_W-BANK_BITS) rows.
  - Consecutive addresses land in consecutive banks.
- DMA port:
  - Write: on a rising edge with dma_write_en=1, mem[bank][row] <= dma_data_in.
  - Read: on a rising edge with dma_read_en=1, dma_data_out <= mem[bank][row]. Data is valid after that edge (1-cycle latency) and is checked one clock after the address is presented.
  - If both strobes are high, read-first: dma_data_out gets the old contents and the write commits.
- PE port i:
  - Always accesses bank i, using row = pe_addr[i][ADDR_W-1:BANK_BITS]; pe_addr[i][BANK_BITS-1:0] is ignored.
  - Write and read follow the DMA rules: 1-cycle read latency, read-first when both strobes are high.
  - All NB PE ports operate concurrently, with no interaction between them.
- Conflicts: DMA has priority on the bank it addresses in a given cycle (dma_read_en or dma_write_en high).
  - That bank's PE access is dropped for the cycle: no write, and pe_data_out[i] holds its value.
  - PE ports on other banks proceed normally.
- Hold: an output register keeps its last value whenever its read strobe is low or its access was blocked.
- Reset (asynchronous, active-high):
  - dma_data_out and all pe_data_out clear to 0 immediately.
  - Memory contents are not cleared: no write occurs during reset, and previously stored data survives a mid-operation reset.
  - Accesses resume on the first rising edge after deassertion.
- Read of a never-written location returns undefined data (X in simulation).
- Address wrap: none needed; every ADDR_W value is a valid word.

Decomposition:
- Package ub_pkg:
  - DATA_W/ADDR_W/NB defaults.
  - BANK_BITS = $clog2(NB); ROW_W = ADDR_W-BANK_BITS.
  - Typedefs word_t, addr_t, row_t.
- Sub-module ub_bank:
  - Single-port synchronous RAM of 2^ROW_W x DATA_W.
  - en/we/row/wdata in, registered rdata out, read-first.
- Top level:
  - Instantiates NB ub_bank instances.
  - Per-bank mux: DMA if selected, else PE i.
  - Registers bank id and the DMA-hit flag one cycle for the dma_data_out select.
  - Owns the output hold registers with async reset.

Test Plan:
- DMA fill and readback:
  - Write addr 0..7 with 0xA000+addr on consecutive cycles.
  - Read 0..7 with one address per cycle; dma_data_out one clock later = 0xA000+addr.
- PE parallel write/read:
  - In one cycle, pe_write_en=4'hF, pe_addr[i]=0x200+i, pe_data_in[i]=0xB0000+i.
  - Then pe_read_en=4'hF with the same addresses; one clock later pe_data_out[i]=0xB0000+i.
- Cross-port visibility:
  - DMA writes addr 0x201 with 0x1234.
  - PE1 reads row 0x80 (addr 0x201) -> 0x1234.
  - PE1 writes that location with 0x5678; DMA read of 0x201 -> 0x5678.
- Conflict priority:
  - Same cycle: DMA writes 0x300 = 0xDEAD; PE0 writes 0x300 = 0xBEEF; PE2 writes 0x302 = 0xCAFE.
  - Readback: 0x300 = 0xDEAD, 0x302 = 0xCAFE; pe_data_out[0] unchanged in the conflict cycle.
- Read-first and hold:
  - Simultaneous DMA read+write of addr 5 (old 0xA005, new 0x55) -> dma_data_out = 0xA005; next read = 0x55.
  - With strobes low, outputs hold.
- Reset:
  - Assert reset mid-stream -> all outputs 0 immediately.
  - After release, a DMA read of addr 3 returns 0xA003 (contents retained).

Source files
------------

// File: rtl/ub_pkg.sv
// Shared definitions for the unified buffer: default geometry, derived
// bank/row widths and the word/address/row types used around the buffer.
package ub_pkg;

  localparam int UB_DATA_W    = 32;
  localparam int UB_ADDR_W    = 10;
  localparam int UB_NB        = 4;
  localparam int UB_BANK_BITS = $clog2(UB_NB);
  localparam int UB_ROW_W     = UB_ADDR_W - UB_BANK_BITS;

  typedef logic [UB_DATA_W-1:0] word_t;
  typedef logic [UB_ADDR_W-1:0] addr_t;
  typedef logic [UB_ROW_W-1:0]  row_t;

endpackage

// File: rtl/ub_bank.sv
// One single-port synchronous RAM bank of the unified buffer.
// Any access (i_en) loads the registered read data with the row's old
// contents, so a simultaneous read+write is read-first. Validity of the
// read data is tracked by the parent, which knows whether a read was asked.
module ub_bank
  import ub_pkg::*;
#(
  parameter int DATA_W = UB_DATA_W,
  parameter int ROW_W  = UB_ROW_W
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ROW_W-1:0]  i_row,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ROW_W];
  logic [DATA_W-1:0] r_rdata;

  // Storage port: capture old contents on access, then commit any write.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_rdata <= r_mem[i_row];
      if (i_we) begin
        r_mem[i_row] <= i_wdata;
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/unified_buffer.sv
// Unified buffer: NB low-order interleaved single-port banks shared by a
// global DMA port and NB bank-local PE ports. The DMA port wins the bank it
// addresses in a cycle; the PE port of that bank is dropped for the cycle.
// Read outputs are the bank read registers while fresh, otherwise a hold
// register with async reset, so outputs clear immediately on reset while
// the bank storage itself is never reset or written during reset.
module unified_buffer
  import ub_pkg::*;
#(
  parameter int DATA_W = UB_DATA_W,
  parameter int ADDR_W = UB_ADDR_W,
  parameter int NB     = UB_NB
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dma_write_en,
  input  logic                       dma_read_en,
  input  logic [ADDR_W-1:0]          dma_addr,
  input  logic [DATA_W-1:0]          dma_data_in,
  output logic [DATA_W-1:0]          dma_data_out,
  input  logic [NB-1:0]              pe_read_en,
  input  logic [NB-1:0]              pe_write_en,
  input  logic [NB-1:0][ADDR_W-1:0]  pe_addr,
  input  logic [NB-1:0][DATA_W-1:0]  pe_data_in,
  output logic [NB-1:0][DATA_W-1:0]  pe_data_out
);

  localparam int BANK_BITS = $clog2(NB);
  localparam int ROW_W     = ADDR_W - BANK_BITS;

  // DMA address decode
  logic [BANK_BITS-1:0] w_dma_bank;
  logic [ROW_W-1:0]     w_dma_row;
  logic                 w_dma_act;

  assign w_dma_bank = dma_addr[BANK_BITS-1:0];
  assign w_dma_row  = dma_addr[ADDR_W-1:BANK_BITS];
  assign w_dma_act  = (dma_read_en | dma_write_en) & ~reset;

  // Per-bank arbitration results and bank port signals
  logic [NB-1:0]     w_dma_sel;
  logic [NB-1:0]     w_pe_rd;
  logic [NB-1:0]     w_pe_wr;
  logic [NB-1:0]     w_bank_en;
  logic [NB-1:0]     w_bank_we;
  logic [ROW_W-1:0]  w_bank_row   [NB];
  logic [DATA_W-1:0] w_bank_wdata [NB];
  logic [DATA_W-1:0] w_bank_rdata [NB];

  // The bank-select bits of a PE address carry no information: port i is
  // hard-wired to bank i.
  logic w_unused_pe_lsbs;

  // Arbitrate each bank: DMA if it targets this bank, else the local PE.
  always_comb begin
    w_unused_pe_lsbs = 1'b0;
    for (int i = 0; i < NB; i++) begin
      w_dma_sel[i]    = w_dma_act && (w_dma_bank == BANK_BITS'(i));
      w_pe_rd[i]      = pe_read_en[i]  & ~reset & ~w_dma_sel[i];
      w_pe_wr[i]      = pe_write_en[i] & ~reset & ~w_dma_sel[i];
      w_bank_en[i]    = w_dma_sel[i] | w_pe_rd[i] | w_pe_wr[i];
      w_bank_we[i]    = w_dma_sel[i] ? dma_write_en : w_pe_wr[i];
      w_bank_row[i]   = w_dma_sel[i] ? w_dma_row : pe_addr[i][ADDR_W-1:BANK_BITS];
      w_bank_wdata[i] = w_dma_sel[i] ? dma_data_in : pe_data_in[i];
      w_unused_pe_lsbs = w_unused_pe_lsbs ^ (^pe_addr[i][BANK_BITS-1:0]);
    end
  end

  genvar g;
  generate
    for (g = 0; g < NB; g++) begin : g_bank
      ub_bank #(
        .DATA_W (DATA_W),
        .ROW_W  (ROW_W)
      ) u_bank (
        .clk     (clk),
        .i_en    (w_bank_en[g]),
        .i_we    (w_bank_we[g]),
        .i_row   (w_bank_row[g]),
        .i_wdata (w_bank_wdata[g]),
        .o_rdata (w_bank_rdata[g])
      );
    end
  endgenerate

  // Which read registers hold fresh data after this edge, and for the DMA
  // port, which bank produced it.
  logic                 r_dma_vld;
  logic [BANK_BITS-1:0] r_dma_bank;
  logic [NB-1:0]        r_pe_vld;

  // Read-valid tracking for the output select (cleared by reset).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dma_vld  <= 1'b0;
      r_dma_bank <= '0;
      r_pe_vld   <= '0;
    end else begin
      r_dma_vld  <= dma_read_en;
      r_dma_bank <= w_dma_bank;
      r_pe_vld   <= w_pe_rd;
    end
  end

  // Last value presented on each output, replayed while no fresh read exists.
  logic [DATA_W-1:0]         r_dma_hold;
  logic [NB-1:0][DATA_W-1:0] r_pe_hold;

  // Output hold registers track whatever was shown; reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dma_hold <= '0;
      r_pe_hold  <= '0;
    end else begin
      r_dma_hold <= dma_data_out;
      r_pe_hold  <= pe_data_out;
    end
  end

  // Present fresh bank data after a granted read, otherwise the held value.
  always_comb begin
    dma_data_out = r_dma_vld ? w_bank_rdata[r_dma_bank] : r_dma_hold;
    for (int i = 0; i < NB; i++) begin
      pe_data_out[i] = r_pe_vld[i] ? w_bank_rdata[i] : r_pe_hold[i];
    end
  end

endmodule

// File: tb/tb_unified_buffer.sv
// Self-checking bench for unified_buffer: directed scenarios followed by a
// randomized run, all checked against a word-addressed reference model.
module tb_unified_buffer;
  import ub_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int NBK = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    dma_write_en;
  logic                    dma_read_en;
  logic [AW-1:0]           dma_addr;
  logic [DW-1:0]           dma_data_in;
  logic [DW-1:0]           dma_data_out;
  logic [NBK-1:0]          pe_read_en;
  logic [NBK-1:0]          pe_write_en;
  logic [NBK-1:0][AW-1:0]  pe_addr;
  logic [NBK-1:0][DW-1:0]  pe_data_in;
  logic [NBK-1:0][DW-1:0]  pe_data_out;

  int errors = 0;
  int checks = 0;

  // Reference: flat memory of global words plus expected output values.
  logic [DW-1:0] ref_mem [1 << AW];
  logic [DW-1:0] exp_dma;
  logic [DW-1:0] exp_pe [NBK];

  always #5 clk = ~clk;

  unified_buffer #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NB     (NBK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dma_write_en (dma_write_en),
    .dma_read_en  (dma_read_en),
    .dma_addr     (dma_addr),
    .dma_data_in  (dma_data_in),
    .dma_data_out (dma_data_out),
    .pe_read_en   (pe_read_en),
    .pe_write_en  (pe_write_en),
    .pe_addr      (pe_addr),
    .pe_data_in   (pe_data_in),
    .pe_data_out  (pe_data_out)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic check_model(input string tag);
    check($sformatf("%s_dma", tag), dma_data_out, exp_dma);
    for (int i = 0; i < NBK; i++)
      check($sformatf("%s_pe%0d", tag, i), pe_data_out[i], exp_pe[i]);
  endtask

  task automatic idle();
    dma_write_en = 1'b0;
    dma_read_en  = 1'b0;
    pe_read_en   = '0;
    pe_write_en  = '0;
  endtask

  // Apply the buffer's rules to the inputs seen at a rising edge:
  // word address a lives in bank a%NB; PE i reaches word (a/NB)*NB+i;
  // an active DMA port takes its bank away from that bank's PE;
  // every read sees the contents from before this edge's writes.
  task automatic model_edge();
    bit blocked [NBK];
    int pa [NBK];
    if (reset) begin
      exp_dma = '0;
      for (int i = 0; i < NBK; i++) exp_pe[i] = '0;
      return;
    end
    for (int i = 0; i < NBK; i++) begin
      pa[i] = (int'(pe_addr[i]) / NBK) * NBK + i;
      blocked[i] = (dma_read_en || dma_write_en) && ((int'(dma_addr) % NBK) == i);
    end
    if (dma_read_en) exp_dma = ref_mem[int'(dma_addr)];
    for (int i = 0; i < NBK; i++)
      if (pe_read_en[i] && !blocked[i]) exp_pe[i] = ref_mem[pa[i]];
    if (dma_write_en) ref_mem[int'(dma_addr)] = dma_data_in;
    for (int i = 0; i < NBK; i++)
      if (pe_write_en[i] && !blocked[i]) ref_mem[pa[i]] = pe_data_in[i];
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Bound the whole run in case the clock or a wait never advances.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    idle();
    dma_addr    = '0;
    dma_data_in = '0;
    pe_addr     = '0;
    pe_data_in  = '0;
    exp_dma     = '0;
    for (int i = 0; i < NBK; i++) exp_pe[i] = '0;

    // Reset state
    tick();
    tick();
    check("rst_dma", dma_data_out, 32'h0);
    for (int i = 0; i < NBK; i++) check($sformatf("rst_pe%0d", i), pe_data_out[i], 32'h0);
    reset = 1'b0;

    // DMA fill 0..7 with 0xA000+addr, then 8..63 with random words
    for (int a = 0; a < 64; a++) begin
      dma_write_en = 1'b1;
      dma_addr     = AW'(a);
      dma_data_in  = (a < 8) ? (32'hA000 + 32'(a)) : $urandom;
      tick();
    end
    idle();

    // DMA readback, one address per cycle
    for (int a = 0; a < 8; a++) begin
      dma_read_en = 1'b1;
      dma_addr    = AW'(a);
      tick();
      check($sformatf("fill_rd%0d", a), dma_data_out, 32'hA000 + 32'(a));
    end
    idle();

    // PE parallel write then read
    pe_write_en = 4'hF;
    for (int i = 0; i < NBK; i++) begin
      pe_addr[i]    = AW'(32'h200 + 32'(i));
      pe_data_in[i] = 32'hB0000 + 32'(i);
    end
    tick();
    pe_write_en = 4'h0;
    pe_read_en  = 4'hF;
    tick();
    for (int i = 0; i < NBK; i++)
      check($sformatf("pe_par%0d", i), pe_data_out[i], 32'hB0000 + 32'(i));
    idle();

    // Cross-port visibility
    dma_write_en = 1'b1;
    dma_addr     = AW'(32'h201);
    dma_data_in  = 32'h1234;
    tick();
    idle();
    pe_read_en = 4'b0010;
    pe_addr[1] = AW'(32'h201);
    tick();
    check("x_pe1_rd", pe_data_out[1], 32'h1234);
    idle();
    pe_write_en   = 4'b0010;
    pe_data_in[1] = 32'h5678;
    tick();
    idle();
    dma_read_en = 1'b1;
    dma_addr    = AW'(32'h201);
    tick();
    check("x_dma_rd", dma_data_out, 32'h5678);
    idle();

    // Conflict: DMA and PE0 both on bank 0, PE2 independent
    dma_write_en  = 1'b1;
    dma_addr      = AW'(32'h300);
    dma_data_in   = 32'hDEAD;
    pe_write_en   = 4'b0101;
    pe_read_en    = 4'b0001;
    pe_addr[0]    = AW'(32'h300);
    pe_data_in[0] = 32'hBEEF;
    pe_addr[2]    = AW'(32'h302);
    pe_data_in[2] = 32'hCAFE;
    tick();
    check("cf_pe0_hold", pe_data_out[0], 32'hB0000);
    idle();
    dma_read_en = 1'b1;
    dma_addr    = AW'(32'h300);
    pe_read_en  = 4'b0100;
    tick();
    check("cf_dma_300", dma_data_out, 32'hDEAD);
    check("cf_pe2_302", pe_data_out[2], 32'hCAFE);
    check("cf_pe0_keep", pe_data_out[0], 32'hB0000);
    idle();

    // Read-first on simultaneous DMA read+write, then hold
    dma_read_en  = 1'b1;
    dma_write_en = 1'b1;
    dma_addr     = AW'(5);
    dma_data_in  = 32'h55;
    tick();
    check("rf_old", dma_data_out, 32'hA005);
    idle();
    dma_read_en = 1'b1;
    tick();
    check("rf_new", dma_data_out, 32'h55);
    idle();
    dma_addr = AW'(1);
    for (int i = 0; i < NBK; i++) pe_addr[i] = AW'(i);
    tick();
    tick();
    check("hold_dma", dma_data_out, 32'h55);
    check("hold_pe0", pe_data_out[0], 32'hB0000);
    check("hold_pe1", pe_data_out[1], 32'h1234);
    check("hold_pe2", pe_data_out[2], 32'hCAFE);
    check("hold_pe3", pe_data_out[3], 32'hB0003);
    check_model("hold_model");

    // Randomized traffic in words 8..63, checked against the model
    for (int n = 0; n < 300; n++) begin
      dma_read_en  = 1'($urandom_range(0, 1));
      dma_write_en = ($urandom_range(0, 2) == 0);
      dma_addr     = AW'(8 + $urandom_range(0, 55));
      dma_data_in  = $urandom;
      pe_read_en   = NBK'($urandom);
      pe_write_en  = NBK'($urandom);
      for (int i = 0; i < NBK; i++) begin
        pe_addr[i]    = AW'(8 + $urandom_range(0, 55));
        pe_data_in[i] = $urandom;
      end
      tick();
      check_model($sformatf("rnd%0d", n));
    end
    idle();

    // Mid-stream async reset with writes pending on words 0..3
    dma_write_en = 1'b1;
    dma_read_en  = 1'b1;
    dma_addr     = AW'(3);
    dma_data_in  = 32'hFFFF_FFFF;
    pe_write_en  = 4'hF;
    pe_read_en   = 4'hF;
    for (int i = 0; i < NBK; i++) begin
      pe_addr[i]    = AW'(i);
      pe_data_in[i] = 32'hEEEE_0000 + 32'(i);
    end
    #3;
    reset = 1'b1;
    #1;
    check("arst_dma", dma_data_out, 32'h0);
    for (int i = 0; i < NBK; i++) check($sformatf("arst_pe%0d", i), pe_data_out[i], 32'h0);
    tick();
    tick();
    check_model("rst_held");
    reset = 1'b0;
    idle();
    dma_read_en = 1'b1;
    dma_addr    = AW'(3);
    tick();
    check("post_rst_dma3", dma_data_out, 32'hA003);
    idle();
    pe_read_en = 4'hF;
    tick();
    for (int i = 0; i < NBK; i++)
      check($sformatf("post_rst_pe%0d", i), pe_data_out[i], 32'hA000 + 32'(i));
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
